multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes
// and the mux-select encodings driven onto the datapath.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operand B select
  localparam logic [1:0] SRCB_RD2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP       = 2'b10;

  // States that hold a memory request open until memReady
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state sequencing with a per-memory-state
// wait timeout, a sticky fault flag, and a state-decoded control word.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       iorD,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       regWriteEnable,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSrc,
  output logic [3:0] state,
  output logic       fault
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Value of the counter on the last permitted wait cycle: one more stall
  // makes it reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             fault_q, fault_d;
  // Low from reset assertion until the first clock edge after release, so the
  // controller idles (no strobes, no advance) during that window.
  logic             run_q, run_d;

  // Next-state, wait-counter and fault-flag computation
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    run_d   = 1'b1;
    if (run_q) begin
      case (state_q)
        S_FETCH, S_MEMREAD, S_MEMWRITE: begin
          // memReady wins over an expiring timeout in the same cycle
          if (memReady) begin
            case (state_q)
              S_FETCH:   state_d = S_DECODE;
              S_MEMREAD: state_d = S_MEMWB;
              default:   state_d = S_FETCH;
            endcase
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_FAULT;
          endcase
        end
        S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_EXECUTE: state_d = S_ALUWB;
        S_ADDIEX:  state_d = S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
        S_FAULT:   state_d = S_FAULT;
        default:   state_d = S_FAULT;
      endcase
      // Every entry into a memory state starts a fresh wait budget
      if ((state_d != state_q) && is_mem_state(state_d)) begin
        wait_d = '0;
      end
      if (state_d == S_FAULT) begin
        fault_d = 1'b1;
      end
    end
  end

  // State, counter and flag registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      fault_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      run_q   <= run_d;
    end
  end

  // Control-word decoder: everything defaults to 0, strobes gated while idle
  always_comb begin
    memReq         = 1'b0;
    memWrite       = 1'b0;
    iorD           = 1'b0;
    irWrite        = 1'b0;
    pcWrite        = 1'b0;
    pcWriteCond    = 1'b0;
    regWriteEnable = 1'b0;
    regDst         = 1'b0;
    memToReg       = 1'b0;
    aluSrcA        = 1'b0;
    aluSrcB        = SRCB_RD2;
    aluOp          = ALUOP_ADD;
    pcSrc          = PCSRC_ALU_RESULT;
    case (state_q)
      S_FETCH: begin
        memReq  = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: aluSrcB = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        memReq = 1'b1;
        iorD   = 1'b1;
      end
      S_MEMWB: begin
        regWriteEnable = 1'b1;
        memToReg       = 1'b1;
      end
      S_MEMWRITE: begin
        memReq   = 1'b1;
        iorD     = 1'b1;
        memWrite = 1'b1;
      end
      S_EXECUTE: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regWriteEnable = 1'b1;
        regDst         = 1'b1;
      end
      S_ADDIWB: regWriteEnable = 1'b1;
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALUOP_SUB;
        pcSrc       = PCSRC_ALU_OUT;
        pcWriteCond = 1'b1;
      end
      S_JUMP: begin
        pcSrc   = PCSRC_JUMP;
        pcWrite = 1'b1;
      end
      default: ;
    endcase
    if (!run_q) begin
      memReq         = 1'b0;
      memWrite       = 1'b0;
      irWrite        = 1'b0;
      pcWrite        = 1'b0;
      pcWriteCond    = 1'b0;
      regWriteEnable = 1'b0;
    end
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: an instruction-level
// model expands each instruction into its expected per-cycle control words.
module tb_multicycle_control;

  localparam int TO = 4;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       fault;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  logic       clock;
  logic       resetN;
  logic [5:0] opcode;
  logic       memReady;
  logic       memReq, memWrite, iorD, irWrite, pcWrite, pcWriteCond;
  logic       regWriteEnable, regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSrc;
  logic [3:0] state;
  logic       fault;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetN(resetN), .opcode(opcode), .memReady(memReady),
    .memReq(memReq), .memWrite(memWrite), .iorD(iorD), .irWrite(irWrite),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond),
    .regWriteEnable(regWriteEnable), .regDst(regDst), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc),
    .state(state), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Control word each state must present, straight from the state table
  function automatic outs_t exp_outs(input int st, input logic rdy);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      1:  o.alu_src_b = 2'b11;
      2, 9: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_req = 1; o.iord = 1; end
      4:  begin o.reg_we = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_req = 1; o.iord = 1; o.mem_write = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_we = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_write_cond = 1; end
      10: o.reg_we = 1;
      11: begin o.pc_src = 2'b10; o.pc_write = 1; end
      12: o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs and record what the DUT must show in it
  task automatic run_cycle(input int st, input logic rdy, input logic [5:0] op);
    exp_t e;
    @(posedge clock);
    #1;
    memReady = rdy;
    opcode   = op;
    e.st = 4'(st);
    e.o  = exp_outs(st, rdy);
    exp_q.push_back(e);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] strobes();
    return {memReq, memWrite, irWrite, pcWrite, pcWriteCond, regWriteEnable};
  endfunction

  // Assert reset mid-cycle and confirm the asynchronous effect, then release
  task automatic do_reset(input string tag);
    @(negedge clock);
    #1;
    resetN   = 1'b0;
    memReady = 1'b0;
    #1;
    chk({tag, "_async_state"}, 32'(state), 32'd0);
    chk({tag, "_async_strobes"}, 32'(strobes()), 32'd0);
    chk({tag, "_async_fault"}, 32'(fault), 32'd0);
    repeat (2) @(negedge clock);
    chk({tag, "_held_strobes"}, 32'(strobes()), 32'd0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    #1;
    chk({tag, "_release_idle"}, 32'({memReq, state}), 32'd0);
  endtask

  // Memory state: `stall` not-ready cycles, then ready unless budget is spent
  task automatic mem_state(input int st, input logic [5:0] op, input int stall, output bit timed_out);
    for (int i = 0; i < stall && i < TO; i++) run_cycle(st, 1'b0, op);
    timed_out = (stall >= TO);
    if (!timed_out) run_cycle(st, 1'b1, op);
  endtask

  task automatic fault_tail(input logic [5:0] op);
    repeat (3) run_cycle(12, rnd_bit(), op);
    do_reset("fault");
  endtask

  // One whole instruction as an ordered walk through its state path
  task automatic run_instr(input logic [5:0] op, input int s_fetch, input int s_mem);
    bit to;
    mem_state(0, op, s_fetch, to);
    if (to) begin fault_tail(op); return; end
    run_cycle(1, rnd_bit(), op);
    case (op)
      LW: begin
        run_cycle(2, rnd_bit(), op);
        mem_state(3, op, s_mem, to);
        if (to) begin fault_tail(op); return; end
        run_cycle(4, rnd_bit(), op);
      end
      SW: begin
        run_cycle(2, rnd_bit(), op);
        mem_state(5, op, s_mem, to);
        if (to) begin fault_tail(op); return; end
      end
      RT:   begin run_cycle(6, rnd_bit(), op); run_cycle(7, rnd_bit(), op); end
      BEQ:  run_cycle(8, rnd_bit(), op);
      ADDI: begin run_cycle(9, rnd_bit(), op); run_cycle(10, rnd_bit(), op); end
      JMP:  run_cycle(11, rnd_bit(), op);
      default: fault_tail(op);
    endcase
  endtask

  // Monitor: one expected control word per active cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("cycle_st%0d", e.st),
            32'({state, memReq, memWrite, iorD, irWrite, pcWrite, pcWriteCond,
                 regWriteEnable, regDst, memToReg, aluSrcA, aluSrcB, aluOp, pcSrc, fault}),
            32'(e));
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    resetN   = 1'b0;
    opcode   = 6'd0;
    memReady = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_strobes", 32'(strobes()), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    #1;
    chk("release_idle", 32'(memReq), 32'd0);

    run_instr(LW, 0, 0);
    run_instr(SW, 0, 3);
    run_instr(BEQ, 1, 0);
    run_instr(RT, 2, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(JMP, 4, 0);
    run_instr(JMP, 3, 0);
    run_instr(LW, 0, 4);

    // Reset in the middle of a MEMREAD wait
    run_cycle(0, 1'b1, LW);
    run_cycle(1, 1'b0, LW);
    run_cycle(2, 1'b0, LW);
    run_cycle(3, 1'b0, LW);
    run_cycle(3, 1'b0, LW);
    do_reset("midread");
    run_instr(ADDI, 3, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (op inside {LW, SW, RT, BEQ, ADDI, JMP});
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op,
                ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, TO - 1)),
                ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, TO - 1)));
    end

    repeat (2) @(posedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
